// File: rtl/nios_hw_port_rx.sv
// NIOS to_hw_port receiver: four-phase handshake into a FWFT FIFO,
// drained by a valid/ready stream toward the SD-card data consumer.
module nios_hw_port_rx #(
   parameter int DATA_W     = 16,
   parameter int FIFO_DEPTH = 16,
   parameter int ADDR_W     = 4
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic [DATA_W-1:0] to_hw_port,
   input  logic [1:0]        to_hw_sig,
   output logic [1:0]        to_sw_sig,
   output logic [DATA_W-1:0] m_data,
   output logic              m_last,
   output logic              m_valid,
   input  logic              m_ready,
   output logic [ADDR_W:0]   fifo_level
);

   typedef enum logic [1:0] {IDLE, BUSY, ACK_WAIT} state_e;

   localparam logic [ADDR_W:0] DEPTH = (ADDR_W+1)'(FIFO_DEPTH);
   localparam logic [ADDR_W:0] ONE   = (ADDR_W+1)'(1);

   state_e            state_q, state_d;
   logic [1:0]        sync1_q, sync2_q;
   logic [1:0]        to_sw_q, to_sw_d;
   logic [ADDR_W:0]   wr_ptr_q, wr_ptr_d;
   logic [ADDR_W:0]   rd_ptr_q, rd_ptr_d;
   logic [DATA_W:0]   mem_q [FIFO_DEPTH];
   logic [DATA_W:0]   mem_d [FIFO_DEPTH];
   logic [ADDR_W:0]   level;
   logic [DATA_W:0]   head;
   logic [1:0]        sig_s;
   logic              full, empty, is_word;
   logic              push, pop, flush;

   assign sig_s   = sync2_q;
   assign level   = wr_ptr_q - rd_ptr_q;
   assign full    = (level == DEPTH);
   assign empty   = (level == '0);
   assign is_word = (sig_s == 2'b01) || (sig_s == 2'b10);
   assign head    = mem_q[rd_ptr_q[ADDR_W-1:0]];

   assign m_valid    = !empty;
   assign m_data     = empty ? '0 : head[DATA_W-1:0];
   assign m_last     = !empty && head[DATA_W];
   assign to_sw_sig  = to_sw_q;
   assign fifo_level = level;

   // IDLE and BUSY only differ in where a full FIFO leaves the FSM
   always_comb begin
      state_d = state_q;
      to_sw_d = to_sw_q;
      push    = 1'b0;
      flush   = 1'b0;
      unique case (state_q)
         IDLE, BUSY: begin
            if (sig_s == 2'b11) begin
               flush   = 1'b1;
               to_sw_d = 2'b11;
               state_d = ACK_WAIT;
            end else if (is_word && !full) begin
               push    = 1'b1;
               to_sw_d = 2'b01;
               state_d = ACK_WAIT;
            end else if (is_word) begin
               to_sw_d = 2'b10;
               state_d = BUSY;
            end else begin
               to_sw_d = 2'b00;
               state_d = IDLE;
            end
         end
         ACK_WAIT: begin
            if (sig_s == 2'b00) begin
               to_sw_d = 2'b00;
               state_d = IDLE;
            end
         end
         default: begin
            to_sw_d = 2'b00;
            state_d = IDLE;
         end
      endcase
   end

   assign pop = !empty && m_ready && !flush;

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      mem_d    = mem_q;
      if (flush) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
      end else begin
         if (push) begin
            mem_d[wr_ptr_q[ADDR_W-1:0]] = {sig_s == 2'b10, to_hw_port};
            wr_ptr_d = wr_ptr_q + ONE;
         end
         if (pop) begin
            rd_ptr_d = rd_ptr_q + ONE;
         end
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q  <= IDLE;
         sync1_q  <= 2'b00;
         sync2_q  <= 2'b00;
         to_sw_q  <= 2'b00;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         for (int i = 0; i < FIFO_DEPTH; i++) begin
            mem_q[i] <= '0;
         end
      end else begin
         state_q  <= state_d;
         sync1_q  <= to_hw_sig;
         sync2_q  <= sync1_q;
         to_sw_q  <= to_sw_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         mem_q    <= mem_d;
      end
   end

endmodule

// File: doc/nios_hw_port_rx.md
# nios_hw_port_rx

Receives 16-bit words that NIOS software posts on the `to_hw_port` / `to_hw_sig` PIOs and returns a four-phase acknowledge on `to_sw_sig`. Accepted words go into a small first-word-fall-through FIFO. The FIFO is drained through a valid/ready stream toward the hardware consumer of SD-card data. The block sits directly downstream of the NIOS system's `to_hw_*` / `to_sw_sig` conduits, on the system clock.

## Interface

**Parameters**
- `DATA_W`, 16: word width; must match the `to_hw_port` width.
- `FIFO_DEPTH`, 16: FIFO entries; power of two, ≥ 2.
- `ADDR_W`, 4: log2(`FIFO_DEPTH`).

**Ports** (clock and reset first)
- `clk`, input, 1: system clock; all logic is on its rising edge.
- `reset_n`, input, 1: reset, asynchronous and active-low.
- `to_hw_port`, input, `DATA_W`: word from software; held stable by software while `to_hw_sig` ≠ 00.
- `to_hw_sig`, input, 2: software command. 00 = idle, 01 = data word, 10 = final word (last), 11 = flush.
- `to_sw_sig`, output, 2: hardware status. 00 = idle, 01 = word accepted, 10 = busy (FIFO full), 11 = flush done.
- `m_data`, output, `DATA_W`: head-of-FIFO word; 0 when the FIFO is empty.
- `m_last`, output, 1: head word was posted with command 10.
- `m_valid`, output, 1: FIFO not empty.
- `m_ready`, input, 1: consumer accepts the head word.
- `fifo_level`, output, `ADDR_W`+1: current occupancy, 0 to `FIFO_DEPTH`.

## Operation

- **Synchronizer.** `to_hw_sig` passes through a 2-flop synchronizer to give `sig_s`. `to_hw_port` is sampled unsynchronized; it has been stable for at least 2 cycles by the time `sig_s` changes.
- **FIFO.** Each entry is `DATA_W`+1 bits: data plus a last bit. It has write and read pointers of `ADDR_W`+1 bits each and wraps modulo `FIFO_DEPTH`.
  - full = level == `FIFO_DEPTH`; empty = level == 0.
- **FSM states:** IDLE, BUSY, ACK_WAIT.
- **IDLE**
  - `sig_s` = 01 or 10, FIFO not full: write {`sig_s`==10, `to_hw_port`}, set `to_sw_sig` <= 01, go to ACK_WAIT.
  - `sig_s` = 01 or 10, FIFO full: set `to_sw_sig` <= 10, go to BUSY.
  - `sig_s` = 11: clear both pointers (flush), set `to_sw_sig` <= 11, go to ACK_WAIT.
  - `sig_s` = 00: stay in IDLE; `to_sw_sig` = 00.
- **BUSY**
  - FIFO not full, `sig_s` still 01/10: write the word, set `to_sw_sig` <= 01, go to ACK_WAIT.
  - `sig_s` = 11: flush as in IDLE.
  - `sig_s` = 00 (software aborted): set `to_sw_sig` <= 00, go to IDLE; no write.
- **ACK_WAIT**
  - Hold `to_sw_sig` until `sig_s` = 00, then set `to_sw_sig` <= 00 and go to IDLE.
  - A command change without passing through 00 is ignored; exactly one write occurs per handshake.
- **Read side.**
  - `m_valid` = !empty; `m_data` and `m_last` are combinational from the entry at the read pointer.
  - Pop when `m_valid` && `m_ready`.
- **Simultaneous push and pop.**
  - Full is evaluated before the pop, so a push in the same cycle as a pop on a full FIFO is refused (BUSY).
  - On a non-full FIFO, push and pop in the same cycle leave the level unchanged.
- **Flush priority.** Flush overrides a same-cycle pop. `m_valid` is 0 from the next cycle.
- **Reset mid-handshake.** FSM returns to IDLE, FIFO empties, `to_sw_sig` = 00.
  - If software still holds 01 after reset, the word is accepted again as a new handshake.

## Timing

- **Reset values:** `to_sw_sig`=00, `m_valid`=0, `m_last`=0, `m_data`=0, `fifo_level`=0, synchronizer flops=00, FSM=IDLE.
- **Acknowledge latency.** `to_hw_sig` 00→01 at edge N gives `sig_s`=01 at N+2; the write and `to_sw_sig`=01 take effect at N+3.
- **Output latency.** `m_valid` rises and `fifo_level` increments at N+3.
- **Release latency.** `to_hw_sig` →00 at edge M gives `to_sw_sig`=00 at M+3.
- **Throughput.** Minimum handshake period is 6 cycles plus software latency.
- **Pop timing.** A pop takes effect at the edge where `m_valid` && `m_ready`; the next head word appears the same edge.
- **Flush timing.** `fifo_level`=0 and `to_sw_sig`=11 both appear 3 cycles after `to_hw_sig`=11.

## Test plan

- **Single word.** After reset, drive port=0xA5C3, sig=01, `m_ready`=0. Required: at +3 cycles `to_sw_sig`=01, `m_valid`=1, `m_data`=0xA5C3, `m_last`=0, level=1. Then sig=00. Required: `to_sw_sig`=00 at +3.
- **Fill to full.** Post 16 words 0x0000..0x000F with `m_ready`=0, then a 17th word 0xFFFF. Required: `to_sw_sig`=10 and level=16. Then `m_ready`=1 for one cycle. Required: 0x0000 popped, 0xFFFF written, `to_sw_sig`=01.
- **Final word.** Post 0x1234 with sig=10. Required: `m_last`=1 when it reaches the head; the previous head has `m_last`=0.
- **Flush.** With 5 words queued and `m_ready`=1 asserted in the same cycle that `sig_s` becomes 11: required level=0, `m_valid`=0, `to_sw_sig`=11; no pop counted.
- **Async reset in ACK_WAIT.** Assert `reset_n`=0 for 1 ns mid-cycle. Required: immediately `to_sw_sig`=00, level=0, `m_valid`=0. Release with sig still 01. Required: the word is re-accepted 3 cycles later.
- **Streaming wrap.** Run 40 words with random `m_ready`. Required: output order equals input order and level never exceeds 16.
